// File: rtl/wide_addsub_seq_pkg.sv
// Shared definitions for the slice-serial add/subtract engine: FSM states,
// default slice width and the slice-index width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_SLICE = 8;

    // A counter needs at least one bit, even when there is only one slice.
    function automatic int idx_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/wide_addsub_seq_add_slice.sv
// Combinational SLICE-bit ripple-carry adder; also exposes the carry into the
// top bit so the sequencer can derive two's-complement overflow.
module add_slice
    import adder_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    // Each bit owns its carry nets so the chain is a set of distinct signals.
    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        logic w_ci;
        logic w_co;
        if (i == 0) begin : g_lsb
            assign w_ci = cin;
        end else begin : g_up
            assign w_ci = g_fa[i-1].w_co;
        end
        assign s[i] = a[i] ^ b[i] ^ w_ci;
        assign w_co = (a[i] & b[i]) | (w_ci & (a[i] ^ b[i]));
    end

    assign cout     = g_fa[SLICE-1].w_co;
    assign c_msb_in = g_fa[SLICE-1].w_ci;

endmodule

// File: rtl/wide_addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract: one SLICE-bit adder is reused for
// WIDTH/SLICE cycles, least-significant slice first, with a registered carry.
module wide_addsub_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = idx_w(NSLICE);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

    state_t           r_state;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_res_valid;

    logic [SLICE-1:0] w_sl_sum;
    logic             w_sl_cout;
    logic             w_sl_cmsb;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_s_nxt;

    add_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a        (r_a[SLICE-1:0]),
        .b        (r_b[SLICE-1:0]),
        .cin      (r_carry),
        .s        (w_sl_sum),
        .cout     (w_sl_cout),
        .c_msb_in (w_sl_cmsb)
    );

    // Operands shift down one slice per cycle; the result fills in from the
    // top, so after NSLICE cycles slice 0 sits at the bottom of r_s.
    if (NSLICE > 1) begin : g_multi
        assign w_a_nxt = {{SLICE{1'b0}}, r_a[WIDTH-1:SLICE]};
        assign w_b_nxt = {{SLICE{1'b0}}, r_b[WIDTH-1:SLICE]};
        assign w_s_nxt = {w_sl_sum, r_s[WIDTH-1:SLICE]};
    end else begin : g_single
        assign w_a_nxt = r_a;
        assign w_b_nxt = r_b;
        assign w_s_nxt = w_sl_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_a         <= a;
                        r_b         <= sub ? ~b : b;
                        r_carry     <= sub;
                        r_idx       <= '0;
                        r_s         <= '0;
                        r_cout      <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_state     <= RUN;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                RUN: begin
                    r_s     <= w_s_nxt;
                    r_a     <= w_a_nxt;
                    r_b     <= w_b_nxt;
                    r_carry <= w_sl_cout;
                    if (r_idx == IDX_LAST) begin
                        r_cout      <= w_sl_cout;
                        r_ovf       <= w_sl_cmsb ^ w_sl_cout;
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign res_valid = r_res_valid;
    assign busy      = r_busy;
    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Bench for wide_addsub_seq (32/8): directed corner cases, backpressure,
// mid-operation reset and random operands against a plain-arithmetic model.
module tb_wide_addsub_seq;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    wide_addsub_seq #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer arithmetic, then reduce to the 32-bit view.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic op,
                         output logic [31:0] es, output logic ec, output logic eo);
        longint sx, sy, r;
        longint ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        r  = op ? (sx - sy) : (sx + sy);
        es = op ? (x - y) : (x + y);
        ec = op ? (ux >= uy) : ((ux + uy) > 64'sd4294967295);
        eo = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endtask

    task automatic wait_result(input string tag, input int start_n);
        int n;
        n = start_n;
        while (!res_valid && n < 20) begin
            a   = $urandom;
            b   = $urandom;
            sub = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        // The accept edge counts as the first of NSLICE+1 edges.
        check({tag, "_latency"}, 64'(n), 64'(NSLICE + 1));
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic op,
                          input string tag);
        logic [31:0] es;
        logic        ec, eo;
        int          n;
        model(x, y, op, es, ec, eo);
        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        a = x; b = y; sub = op; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check({tag, "_busy"}, 64'({busy, cmd_ready}), 64'b10);
        wait_result(tag, 1);
        check({tag, "_s"}, 64'(s), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, "_release"}, 64'({res_valid, cmd_ready, busy}), 64'b010);
    endtask

    initial begin
        logic [31:0] es1, es2;
        logic        ec1, eo1, ec2, eo2;

        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        step();
        step();
        check("reset_outputs", 64'({s, cout, ovf, res_valid, busy, cmd_ready}), 64'd1);
        rst_n = 1'b1;
        step();

        run_op(32'h000000FF, 32'h00000001, 1'b0, "add_carry_slice");
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, "add_wrap");
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, "add_ovf");
        run_op(32'h00000007, 32'h00000005, 1'b1, "sub_7_5");
        run_op(32'h00000005, 32'h00000007, 1'b1, "sub_5_7");
        run_op(32'h80000000, 32'h00000001, 1'b1, "sub_ovf");
        run_op(32'h00000000, 32'h00000000, 1'b1, "sub_zero");

        // Backpressure: result held while a second command waits.
        model(32'hDEADBEEF, 32'h01020304, 1'b0, es1, ec1, eo1);
        model(32'h00001000, 32'h00002000, 1'b1, es2, ec2, eo2);
        a = 32'hDEADBEEF; b = 32'h01020304; sub = 1'b0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        wait_result("bp_first", 1);
        a = 32'h00001000; b = 32'h00002000; sub = 1'b1; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_s", 64'(s), 64'(es1));
            check("bp_hold_flags", 64'({cout, ovf, res_valid, cmd_ready}), 64'({ec1, eo1, 2'b10}));
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp_release", 64'({res_valid, cmd_ready}), 64'b01);
        step();
        cmd_valid = 1'b0;
        check("bp_second_accept", 64'({busy, cmd_ready}), 64'b10);
        wait_result("bp_second", 1);
        check("bp_second_s", 64'(s), 64'(es2));
        check("bp_second_flags", 64'({cout, ovf}), 64'({ec2, eo2}));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Reset asserted before the second RUN edge.
        a = 32'h000000AA; b = 32'h00000011; sub = 1'b0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_now", 64'({s, cout, ovf, res_valid, busy, cmd_ready}), 64'd1);
        step();
        check("midrst_hold", 64'({s, cout, ovf, res_valid, busy, cmd_ready}), 64'd1);
        rst_n = 1'b1;
        step();
        check("midrst_no_result", 64'(res_valid), 64'd0);
        run_op(32'h12345678, 32'h11111111, 1'b0, "post_reset");
        check("post_reset_value", 64'(es1 == 32'h23456789), 64'd0);

        for (int i = 0; i < 24; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
